// File: rtl/game_score_timer_pkg.sv
// Shared types and constants for the whack-a-mole score/timer block.
// Holds the FSM state encoding, the BCD geometry and the integer-to-BCD helper.
package game_score_timer_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

    localparam logic [BCD_W-1:0] BCD_MAX  = 16'h9999;
    localparam logic [BCD_W-1:0] BCD_ZERO = 16'h0000;
    localparam logic [BCD_W-1:0] BCD_ONE  = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Used only on parameters, so it folds to a constant at elaboration.
    function automatic logic [BCD_W-1:0] int_to_bcd4(input int unsigned value);
        logic [BCD_W-1:0] bcd;
        int unsigned      rem;
        bcd = '0;
        rem = value;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(rem % 10);
            rem = rem / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/game_score_timer_bcd_counter4.sv
// Four-digit packed-BCD register with load, increment and decrement.
// Increment saturates at 9999, decrement floors at 0000; inc and dec together hold.
module bcd_counter4
    import game_score_timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] RESET_VAL = '0
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_value
);

    logic [BCD_W-1:0] r_value;
    logic [BCD_W-1:0] w_inc_val;
    logic [BCD_W-1:0] w_dec_val;
    logic             w_carry;
    logic             w_borrow;

    // Ripple carry/borrow through the digits, least significant first.
    always_comb begin
        w_inc_val = r_value;
        w_dec_val = r_value;
        w_carry   = 1'b1;
        w_borrow  = 1'b1;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (w_carry) begin
                if (r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    w_inc_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    w_inc_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                        r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    w_carry = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0) begin
                    w_dec_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
                end else begin
                    w_dec_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                        r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_value <= RESET_VAL;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc && !i_dec && (r_value != BCD_MAX)) begin
            r_value <= w_inc_val;
        end else if (i_dec && !i_inc && (r_value != BCD_ZERO)) begin
            r_value <= w_dec_val;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/game_score_timer.sv
// Game FSM, one-second prescaler, BCD countdown timer and saturating score.
// Drives the packed {timer, score} BCD word for the display driver.
module game_score_timer
    import game_score_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned GAME_SECONDS = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic [31:0] count,
    output logic        tick,
    output logic        game_active,
    output logic        game_over
);

    localparam logic [BCD_W-1:0] TIMER_INIT = int_to_bcd4(GAME_SECONDS);
    localparam int unsigned      PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic             r_active;
    logic             r_over;
    logic [BCD_W-1:0] w_timer;
    logic [BCD_W-1:0] w_score;
    logic             w_running;
    logic             w_start_game;
    logic             w_sec_edge;
    logic             w_last_sec;

    assign w_running    = (r_state == ST_RUN);
    assign w_start_game = start && !w_running;
    assign w_sec_edge   = w_running && (r_presc == PRESC_LAST);
    // Timer is at least 0001 while running, so 0001 on a second edge means it reaches zero.
    assign w_last_sec   = w_sec_edge && (w_timer == BCD_ONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_active <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_tick <= w_sec_edge;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_presc  <= '0;
                        r_active <= 1'b1;
                        r_over   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_presc <= w_sec_edge ? '0 : r_presc + 1'b1;
                    if (w_last_sec) begin
                        r_state  <= ST_OVER;
                        r_active <= 1'b0;
                        r_over   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_presc  <= '0;
                    r_active <= 1'b0;
                    r_over   <= 1'b0;
                end
            endcase
        end
    end

    bcd_counter4 #(
        .RESET_VAL (BCD_ZERO)
    ) u_score (
        .i_clock    (clock),
        .i_reset_n  (reset),
        .i_load     (w_start_game),
        .i_load_val (BCD_ZERO),
        .i_inc      (hit && w_running),
        .i_dec      (miss && w_running),
        .o_value    (w_score)
    );

    bcd_counter4 #(
        .RESET_VAL (TIMER_INIT)
    ) u_timer (
        .i_clock    (clock),
        .i_reset_n  (reset),
        .i_load     (w_start_game),
        .i_load_val (TIMER_INIT),
        .i_inc      (1'b0),
        .i_dec      (w_sec_edge),
        .o_value    (w_timer)
    );

    assign count       = {w_timer, w_score};
    assign tick        = r_tick;
    assign game_active = r_active;
    assign game_over   = r_over;

endmodule

// File: tb/tb_game_score_timer.sv
// Directed bench for game_score_timer: three instances cover the short game,
// the BCD carry/borrow game and the score saturation game.
module tb_game_score_timer;

    logic        clock;
    logic        rst_n;
    logic        start_a, hit_a, miss_a;
    logic        start_b, hit_b, miss_b;
    logic        start_c, hit_c, miss_c;
    logic [31:0] count_a, count_b, count_c;
    logic        tick_a, tick_b, tick_c;
    logic        act_a, act_b, act_c;
    logic        over_a, over_b, over_c;
    logic        digit_bad;
    int unsigned n_cmp;
    int unsigned n_err;

    game_score_timer #(.TICK_DIV(4), .GAME_SECONDS(3)) dut_a (
        .clock(clock), .reset(rst_n), .start(start_a), .hit(hit_a), .miss(miss_a),
        .count(count_a), .tick(tick_a), .game_active(act_a), .game_over(over_a)
    );

    game_score_timer #(.TICK_DIV(2), .GAME_SECONDS(100)) dut_b (
        .clock(clock), .reset(rst_n), .start(start_b), .hit(hit_b), .miss(miss_b),
        .count(count_b), .tick(tick_b), .game_active(act_b), .game_over(over_b)
    );

    game_score_timer #(.TICK_DIV(100000), .GAME_SECONDS(9999)) dut_c (
        .clock(clock), .reset(rst_n), .start(start_c), .hit(hit_c), .miss(miss_c),
        .count(count_c), .tick(tick_c), .game_active(act_c), .game_over(over_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit bcd_ok(input logic [31:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(negedge clock) begin
        if (!bcd_ok(count_a) || !bcd_ok(count_b) || !bcd_ok(count_c)) digit_bad = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs on instance sel, then sample 1 ns after the edge.
    task automatic cyc(input int sel, input logic s, input logic h, input logic m);
        case (sel)
            0: begin start_a = s; hit_a = h; miss_a = m; end
            1: begin start_b = s; hit_b = h; miss_b = m; end
            default: begin start_c = s; hit_c = h; miss_c = m; end
        endcase
        @(posedge clock);
        #1;
        start_a = 0; hit_a = 0; miss_a = 0;
        start_b = 0; hit_b = 0; miss_b = 0;
        start_c = 0; hit_c = 0; miss_c = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; digit_bad = 1'b0;
        rst_n = 1'b0;
        start_a = 0; hit_a = 0; miss_a = 0;
        start_b = 0; hit_b = 0; miss_b = 0;
        start_c = 0; hit_c = 0; miss_c = 0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_count_a", count_a, 32'h0003_0000);
        check_val("rst_flags_a", {tick_a, act_a, over_a}, 3'b000);
        check_val("rst_count_b", count_b, 32'h0100_0000);
        check_val("rst_count_c", count_c, 32'h9999_0000);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a running game.
        cyc(0, 1, 0, 0);
        check_val("start_active", act_a, 1'b1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check_val("two_hits", count_a, 32'h0003_0002);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_rst_count", count_a, 32'h0003_0000);
        check_val("async_rst_flags", {tick_a, act_a, over_a}, 3'b000);
        @(posedge clock);
        #1 rst_n = 1'b1;

        cyc(0, 0, 1, 0);
        check_val("hit_idle", count_a, 32'h0003_0000);
        check_val("hit_idle_act", act_a, 1'b0);

        // Main short game: TICK_DIV=4, GAME_SECONDS=3.
        cyc(0, 1, 0, 0);
        check_val("run_count", count_a, 32'h0003_0000);
        check_val("run_flags", {act_a, over_a}, 2'b10);
        repeat (3) cyc(0, 0, 1, 0);
        check_val("three_hits", count_a, 32'h0003_0003);
        check_val("no_tick_yet", tick_a, 1'b0);
        cyc(0, 0, 1, 0);
        check_val("tick1_count", count_a, 32'h0002_0004);
        check_val("tick1", tick_a, 1'b1);
        cyc(0, 1, 0, 0);
        check_val("start_in_run", count_a, 32'h0002_0004);
        check_val("tick1_one_cycle", tick_a, 1'b0);
        check_val("start_in_run_act", act_a, 1'b1);
        repeat (2) cyc(0, 0, 0, 0);
        check_val("tick_gap", tick_a, 1'b0);
        cyc(0, 0, 0, 0);
        check_val("tick2_count", count_a, 32'h0001_0004);
        check_val("tick2", tick_a, 1'b1);
        repeat (4) cyc(0, 0, 0, 0);
        check_val("tick3_count", count_a, 32'h0000_0004);
        check_val("over_flags", {tick_a, act_a, over_a}, 3'b101);
        cyc(0, 0, 1, 0);
        check_val("hit_over", count_a, 32'h0000_0004);
        check_val("over_no_tick", tick_a, 1'b0);
        cyc(0, 0, 0, 1);
        check_val("miss_over", count_a, 32'h0000_0004);

        // Restart from OVER; prescaler restarts from zero.
        cyc(0, 1, 0, 0);
        check_val("restart_count", count_a, 32'h0003_0000);
        check_val("restart_flags", {act_a, over_a}, 2'b10);
        repeat (3) cyc(0, 0, 0, 0);
        check_val("restart_no_tick", tick_a, 1'b0);
        cyc(0, 0, 0, 0);
        check_val("restart_tick", tick_a, 1'b1);
        check_val("restart_tick_count", count_a, 32'h0002_0000);
        cyc(0, 0, 0, 1);
        check_val("miss_floor", count_a, 32'h0002_0000);
        repeat (5) cyc(0, 0, 1, 0);
        check_val("five_hits", count_a, 32'h0001_0005);
        cyc(0, 0, 1, 1);
        check_val("hit_and_miss", count_a, 32'h0001_0005);
        cyc(0, 0, 1, 0);
        check_val("hit_on_final_tick", count_a, 32'h0000_0006);
        check_val("final_over", over_a, 1'b1);

        // BCD carry and borrow: TICK_DIV=2, GAME_SECONDS=100.
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check_val("b_first_hit", count_b, 32'h0100_0001);
        cyc(1, 0, 1, 0);
        check_val("b_timer_borrow", count_b, 32'h0099_0002);
        check_val("b_tick", tick_b, 1'b1);
        repeat (97) cyc(1, 0, 1, 0);
        check_val("b_99_hits", count_b, 32'h0051_0099);
        cyc(1, 0, 1, 0);
        check_val("b_score_carry", count_b, 32'h0050_0100);

        // Score saturation: TICK_DIV=100000, GAME_SECONDS=9999.
        cyc(2, 1, 0, 0);
        repeat (10005) cyc(2, 0, 1, 0);
        check_val("c_saturate", count_c, 32'h9999_9999);
        cyc(2, 0, 0, 1);
        check_val("c_miss_from_max", count_c, 32'h9999_9998);

        check_val("bcd_digits", digit_bad, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
